// File: rtl/n_adder_pkg.sv
// Shared ALU arithmetic definitions: carry-lookahead group width, the flag
// bundle carried alongside a registered result, and overflow detection.
package n_adder_pkg;

  localparam int ADDER_GROUP_W = 4;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } adder_flags_t;

  // Two's complement overflow: the carry into the MSB disagrees with the carry out of it.
  function automatic logic signed_ovf(input logic c_into_msb, input logic c_out_msb);
    return c_into_msb ^ c_out_msb;
  endfunction

endpackage

// File: rtl/n_adder_cla4.sv
// 4-bit carry-lookahead group: sum bits, group propagate/generate, and the
// carry into bit 3 so the top level can detect signed overflow.
module cla4
  import n_adder_pkg::*;
(
  input  logic [ADDER_GROUP_W-1:0] a,
  input  logic [ADDER_GROUP_W-1:0] b,
  input  logic                     ci,
  output logic [ADDER_GROUP_W-1:0] s,
  output logic                     P,
  output logic                     G,
  output logic                     c3
);

  logic [ADDER_GROUP_W-1:0] p;
  logic [ADDER_GROUP_W-1:0] g;
  logic                     c1;
  logic                     c2;

  assign p = a ^ b;
  assign g = a & b;

  // Every internal carry is a flat function of ci, so no ripple inside the group.
  assign c1 = g[0] | (p[0] & ci);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

  assign s = p ^ {c3, c2, c1, ci};

  assign P = &p;
  assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/n_adder.sv
// N-bit adder for the ALU datapath: combinational sum/carry/overflow plus a
// one-cycle registered copy with a zero flag for pipelined consumers.
module n_adder
  import n_adder_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ovf,
  output logic [N-1:0] s_q,
  output logic         cout_q,
  output logic         ovf_q,
  output logic         zero_q
);

  localparam int NG = N / ADDER_GROUP_W;

  generate
    if (N <= 0 || (N % ADDER_GROUP_W) != 0) begin : g_bad_width
      $fatal(1, "n_adder: N=%0d must be a positive multiple of %0d", N, ADDER_GROUP_W);
    end
  endgenerate

  logic [NG:0]   c;
  logic [NG-1:0] grp_p;
  logic [NG-1:0] grp_g;
  logic [NG-1:0] grp_c3;
  logic          c_into_msb;
  logic          unused_c3;

  assign c[0] = cin;

  // Groups are chained by their P/G terms; only the last group's c3 feeds overflow.
  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    cla4 u_cla4 (
      .a  (a[ADDER_GROUP_W*gi +: ADDER_GROUP_W]),
      .b  (b[ADDER_GROUP_W*gi +: ADDER_GROUP_W]),
      .ci (c[gi]),
      .s  (s[ADDER_GROUP_W*gi +: ADDER_GROUP_W]),
      .P  (grp_p[gi]),
      .G  (grp_g[gi]),
      .c3 (grp_c3[gi])
    );
    assign c[gi+1] = grp_g[gi] | (grp_p[gi] & c[gi]);
  end

  assign cout       = c[NG];
  assign c_into_msb = grp_c3[NG-1];
  assign ovf        = signed_ovf(c_into_msb, cout);
  assign unused_c3  = ^grp_c3;

  logic [N-1:0] s_d;
  adder_flags_t flags_d;
  adder_flags_t flags_q;

  always_comb begin
    s_d          = s;
    flags_d.cout = cout;
    flags_d.ovf  = ovf;
    flags_d.zero = (s == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= '0;
      flags_q <= '0;
    end else begin
      s_q     <= s_d;
      flags_q <= flags_d;
    end
  end

  assign cout_q = flags_q.cout;
  assign ovf_q  = flags_q.ovf;
  assign zero_q = flags_q.zero;

endmodule

// File: tb/tb_n_adder.sv
// Bench for n_adder at N=32 and N=8: directed boundary cases, an asynchronous
// reset scenario and a randomized sweep against an arithmetic reference.
module tb_n_adder;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [31:0] a32 = '0, b32 = '0;
  logic        cin32 = 1'b0;
  logic [31:0] s32, s32_q;
  logic        cout32, ovf32, cout32_q, ovf32_q, zero32_q;

  logic [7:0]  a8 = '0, b8 = '0;
  logic        cin8 = 1'b0;
  logic [7:0]  s8, s8_q;
  logic        cout8, ovf8, cout8_q, ovf8_q, zero8_q;

  n_adder #(.N(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .a(a32), .b(b32), .cin(cin32),
    .s(s32), .cout(cout32), .ovf(ovf32),
    .s_q(s32_q), .cout_q(cout32_q), .ovf_q(ovf32_q), .zero_q(zero32_q)
  );

  n_adder #(.N(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8),
    .s(s8), .cout(cout8), .ovf(ovf8),
    .s_q(s8_q), .cout_q(cout8_q), .ovf_q(ovf8_q), .zero_q(zero8_q)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [34:0] exp32_q[$];
  logic [10:0] exp8_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: {s, cout, ovf, zero} straight from wide arithmetic.
  function automatic logic [34:0] model32(input logic [31:0] a, input logic [31:0] b, input logic ci);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b} + {32'b0, ci};
    return {sum[31:0], sum[32], ((a[31] == b[31]) && (sum[31] != a[31])), (sum[31:0] == 32'd0)};
  endfunction

  function automatic logic [10:0] model8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b} + {8'b0, ci};
    return {sum[7:0], sum[8], ((a[7] == b[7]) && (sum[7] != a[7])), (sum[7:0] == 8'd0)};
  endfunction

  // Registered outputs must equal the model of whatever was on the inputs at the edge.
  always @(posedge clk) begin
    if (rst_n) begin
      exp32_q.push_back(model32(a32, b32, cin32));
      exp8_q.push_back(model8(a8, b8, cin8));
    end
  end

  // Single compare process: registered outputs at negedge, combinational 2 ns later.
  always begin
    logic [34:0] e32;
    logic [10:0] e8;
    @(negedge clk);
    if (!rst_n) begin
      chk("rst s32_q", s32_q, 0);
      chk("rst flags32", {cout32_q, ovf32_q, zero32_q}, 0);
      chk("rst s8_q", s8_q, 0);
      chk("rst flags8", {cout8_q, ovf8_q, zero8_q}, 0);
      exp32_q.delete();
      exp8_q.delete();
    end else if (exp32_q.size() > 0 && exp8_q.size() > 0) begin
      e32 = exp32_q.pop_front();
      e8  = exp8_q.pop_front();
      chk("reg s32_q", s32_q, e32[34:3]);
      chk("reg flags32", {cout32_q, ovf32_q, zero32_q}, e32[2:0]);
      chk("reg s8_q", s8_q, e8[10:3]);
      chk("reg flags8", {cout8_q, ovf8_q, zero8_q}, e8[2:0]);
    end
    #2;
    e32 = model32(a32, b32, cin32);
    e8  = model8(a8, b8, cin8);
    chk("comb s32", s32, e32[34:3]);
    chk("comb cout/ovf32", {cout32, ovf32}, e32[2:1]);
    chk("comb s8", s8, e8[10:3]);
    chk("comb cout/ovf8", {cout8, ovf8}, e8[2:1]);
  end

  // ---------------- driver tasks ----------------
  task automatic drive32(input logic [31:0] a, input logic [31:0] b, input logic ci);
    @(negedge clk);
    a32 = a; b32 = b; cin32 = ci;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    #1;
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h80;
      3: return 8'h7F;
      default: return 8'($urandom);
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    #3 rst_n = 1'b1;

    chk("pin model32", model32(32'h7FFF_FFFF, 32'h1, 1'b0), {32'h8000_0000, 1'b0, 1'b1, 1'b0});
    chk("pin model8", model8(8'hFF, 8'h01, 1'b0), {8'h00, 1'b1, 1'b0, 1'b1});

    drive32(32'h1111_1111, 32'hEEEE_EEEE, 1'b0);
    chk("d1 s", s32, 32'hFFFF_FFFF);
    chk("d1 cout/ovf", {cout32, ovf32}, 2'b00);

    drive32(32'h1111_1111, 32'hEEEE_EEEE, 1'b1);
    chk("d2 s", s32, 32'h0);
    chk("d2 cout/ovf", {cout32, ovf32}, 2'b10);
    @(posedge clk); #1;
    chk("d2 s_q", s32_q, 32'h0);
    chk("d2 cout_q/zero_q", {cout32_q, zero32_q}, 2'b11);

    drive32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    chk("d3 s", s32, 32'h8000_0000);
    chk("d3 cout/ovf", {cout32, ovf32}, 2'b01);
    @(posedge clk); #1;
    chk("d3 ovf_q/zero_q", {ovf32_q, zero32_q}, 2'b10);

    drive32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    chk("d4 s", s32, 32'hFFFF_FFFF);
    chk("d4 cout/ovf", {cout32, ovf32}, 2'b10);

    drive32(32'h8000_0000, 32'h8000_0000, 1'b0);
    chk("d5 s", s32, 32'h0);
    chk("d5 cout/ovf", {cout32, ovf32}, 2'b11);

    drive32(32'hFFFF_FFFF, 32'h0, 1'b1);
    chk("d6 s", s32, 32'h0);
    chk("d6 cout", cout32, 1'b1);

    drive32(32'h0, 32'h0, 1'b0);
    @(posedge clk); #1;
    chk("d7 zero_q/cout_q", {zero32_q, cout32_q}, 2'b10);

    // Asynchronous reset in the middle of a cycle.
    drive32(32'h7FFF_FFFF, 32'h1, 1'b0);
    @(posedge clk); #1;
    chk("r0 s_q loaded", s32_q, 32'h8000_0000);
    #2 rst_n = 1'b0;
    #1;
    chk("r1 s_q cleared", s32_q, 32'h0);
    chk("r1 flags cleared", {cout32_q, ovf32_q, zero32_q}, 3'b000);
    chk("r1 s8_q cleared", s8_q, 8'h0);
    a32 = 32'd5; b32 = 32'd6; cin32 = 1'b0;
    #1;
    chk("r2 s tracks", s32, 32'd11);
    chk("r2 cout/ovf", {cout32, ovf32}, 2'b00);
    @(negedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("r3 first capture", s32_q, 32'd11);
    chk("r3 zero_q", zero32_q, 1'b0);

    // Randomized sweep on both widths.
    repeat (10000) begin
      @(negedge clk);
      a32 = pick32(); b32 = pick32(); cin32 = 1'($urandom);
      a8  = pick8();  b8  = pick8();  cin8  = 1'($urandom);
    end
    repeat (2) @(negedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
